// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing scheduler: opcodes, flag indices,
// default ALU latency and the in-flight tag type.
package alu_ctrl_pkg;

  localparam int unsigned ADD  = 0;
  localparam int unsigned SUB  = 1;
  localparam int unsigned MUL  = 2;
  localparam int unsigned NAND = 3;
  localparam int unsigned SNE  = 4;
  localparam int unsigned DIV  = 5;
  localparam int unsigned MAX  = 6;
  localparam int unsigned ROR  = 7;
  localparam int unsigned SRL  = 8;
  localparam int unsigned NOR  = 9;
  localparam int unsigned SGT  = 10;
  localparam int unsigned MIN  = 11;

  localparam int unsigned CARRY = 3;
  localparam int unsigned ZERO  = 2;
  localparam int unsigned OVF   = 1;
  localparam int unsigned SIGN  = 0;

  localparam int unsigned ALU_LAT_DEFAULT = 2;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotation: the search starts one past the
// last granted requester and wraps modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned LGW = $clog2(N)
) (
  input  logic [N-1:0]   eligible_i,
  input  logic [LGW-1:0] last_grant_i,
  output logic [N-1:0]   grant_o
);

  always_comb begin
    logic        found;
    int unsigned idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant_i) + k) % N;
      if (!found && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// Shares one pipelined ALU among NUM_REQ requesters: round-robin issue,
// registered ALU inputs, and a tag pipe that routes each result home.
module alu_share_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned OPW     = 4,
  parameter int unsigned SHW     = 5,
  parameter int unsigned ALU_LAT = ALU_LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OPW-1:0]   req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SHW-1:0]   req_shift,
  output logic [OPW-1:0]           alu_opcode,
  output logic [WIDTH-1:0]         alu_in1,
  output logic [WIDTH-1:0]         alu_in2,
  output logic [SHW-1:0]           alu_shift,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [3:0]               alu_flags,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [3:0]               rsp_flags,
  output logic                     idle
);

  localparam int unsigned LGW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [NUM_REQ-1:0] eligible, grant;
  logic [LGW-1:0]     last_grant_q, last_grant_d;
  logic [LGW-1:0]     grant_idx;
  logic               hs;

  logic [OPW-1:0]   opcode_q, opcode_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [SHW-1:0]   shift_q, shift_d;

  // Entry 0 travels with the issue registers; entries 1..ALU_LAT follow the
  // ALU's internal latency, so the last entry lines up with alu_result.
  tag_t tag_q [ALU_LAT+1];
  tag_t tag_d;

  rr_arbiter #(
    .N   (NUM_REQ),
    .LGW (LGW)
  ) u_arb (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[ALU_LAT].valid && (tag_q[ALU_LAT].id == ID_W'(i));
    end
  end

  assign eligible  = req_valid & (~busy_q | rsp_valid);
  assign req_ready = grant;
  assign hs        = |grant;

  always_comb begin
    grant_idx = '0;
    opcode_d  = opcode_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    shift_d   = shift_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = LGW'(i);
        opcode_d  = req_opcode[i*OPW +: OPW];
        in1_d     = req_a[i*WIDTH +: WIDTH];
        in2_d     = req_b[i*WIDTH +: WIDTH];
        shift_d   = req_shift[i*SHW +: SHW];
      end
    end
  end

  always_comb begin
    tag_d.valid  = hs;
    tag_d.id     = ID_W'(grant_idx);
    // A new grant at the same edge as the response re-arms busy.
    busy_d       = (busy_q & ~rsp_valid) | grant;
    last_grant_d = hs ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      last_grant_q <= LGW'(NUM_REQ - 1);
      opcode_q     <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      shift_q      <= '0;
      for (int unsigned k = 0; k <= ALU_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      opcode_q     <= opcode_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      shift_q      <= shift_d;
      tag_q[0]     <= tag_d;
      for (int unsigned k = 1; k <= ALU_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign alu_opcode = opcode_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_shift  = shift_q;
  assign rsp_data   = alu_result;
  assign rsp_flags  = alu_flags;
  assign idle       = ~(|req_valid) & ~(|busy_q);

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Directed bench for alu_share_scheduler with a two-stage behavioural ALU.
module tb_alu_share_scheduler;
  import alu_ctrl_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 128;
  localparam int unsigned OPW     = 4;
  localparam int unsigned SHW     = 5;
  localparam int unsigned ALU_LAT = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*OPW-1:0]   req_opcode;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*SHW-1:0]   req_shift;
  logic [OPW-1:0]           alu_opcode;
  logic [WIDTH-1:0]         alu_in1;
  logic [WIDTH-1:0]         alu_in2;
  logic [SHW-1:0]           alu_shift;
  logic [WIDTH-1:0]         alu_result;
  logic [3:0]               alu_flags;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic [3:0]               rsp_flags;
  logic                     idle;

  int total;
  int bad;

  alu_share_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .OPW     (OPW),
    .SHW     (SHW),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_shift  (req_shift),
    .alu_opcode (alu_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_shift  (alu_shift),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH+3:0] alu_f(input logic [OPW-1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [SHW-1:0] sh);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OPW'(ADD): begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(SUB): begin
        r = a - b;
        c = (a < b);
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(MUL): r = a * b;
      OPW'(SRL): r = a >> sh;
      default:   r = '0;
    endcase
    return {c, (r == '0), v, r[WIDTH-1], r};
  endfunction

  // Input register at the first edge, result register at the second.
  logic [WIDTH+3:0] alu_s1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_s1     <= '0;
      alu_result <= '0;
      alu_flags  <= '0;
    end else begin
      alu_s1                  <= alu_f(alu_opcode, alu_in1, alu_in2, alu_shift);
      {alu_flags, alu_result} <= alu_s1;
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    req_valid = '0;
  endtask

  task automatic set_req(input int i, input int unsigned op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh);
    req_opcode[i*OPW +: OPW]   = OPW'(op);
    req_a[i*WIDTH +: WIDTH]    = a;
    req_b[i*WIDTH +: WIDTH]    = b;
    req_shift[i*SHW +: SHW]    = sh;
    req_valid[i]               = 1'b1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_shift  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    total++; if (alu_opcode !== '0 || alu_in1 !== '0 || alu_in2 !== '0 || alu_shift !== '0) begin
      bad++; $display("FAIL reset_alu: got op=%h in1=%h in2=%h sh=%h want all 0", alu_opcode, alu_in1, alu_in2, alu_shift); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    total++; if (rsp_data !== '0 || rsp_flags !== 4'b0000) begin
      bad++; $display("FAIL reset_rsp_data: got %h/%b want 0/0000", rsp_data, rsp_flags); end
    next_cycle();
  endtask

  task automatic test_single;
    do_reset();
    set_req(1, ADD, 128'd5, 128'd7, '0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", idle); end
    next_cycle(); clr();
    @(negedge clk);
    total++; if (alu_opcode !== 4'd0 || alu_in1 !== 128'd5 || alu_in2 !== 128'd7) begin
      bad++; $display("FAIL single_issue: got op=%h in1=%h in2=%h want 0/5/7", alu_opcode, alu_in1, alu_in2); end
    next_cycle();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_early_rsp: got %b want 0000", rsp_valid); end
    next_cycle();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
    total++; if (rsp_data !== 128'd12) begin bad++; $display("FAIL single_rsp_data: got %h want c", rsp_data); end
    total++; if (rsp_flags[CARRY] !== 1'b0 || rsp_flags[ZERO] !== 1'b0) begin
      bad++; $display("FAIL single_rsp_flags: got %b want carry=0 zero=0", rsp_flags); end
    next_cycle();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0000 || idle !== 1'b1) begin
      bad++; $display("FAIL single_after: got rsp=%b idle=%b want 0000/1", rsp_valid, idle); end
    next_cycle();
  endtask

  task automatic test_tag_routing;
    do_reset();
    set_req(2, MUL, 128'd3, 128'd4, '0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL route_ready2: got %b want 0100", req_ready); end
    next_cycle(); clr();
    set_req(3, SRL, 128'h80, 128'd0, 5'd3);
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL route_ready3: got %b want 1000", req_ready); end
    next_cycle(); clr();
    next_cycle();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0100 || rsp_data !== 128'd12) begin
      bad++; $display("FAIL route_rsp2: got %b/%h want 0100/c", rsp_valid, rsp_data); end
    next_cycle();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b1000 || rsp_data !== 128'h10) begin
      bad++; $display("FAIL route_rsp3: got %b/%h want 1000/10", rsp_valid, rsp_data); end
    next_cycle();
  endtask

  task automatic test_overflow;
    do_reset();
    set_req(2, ADD, '1, 128'd1, '0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL ovf_ready: got %b want 0100", req_ready); end
    next_cycle(); clr();
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL ovf_rsp_valid: got %b want 0100", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL ovf_rsp_data: got %h want 0", rsp_data); end
    total++; if (rsp_flags !== 4'b1100) begin bad++; $display("FAIL ovf_rsp_flags: got %b want 1100", rsp_flags); end
    next_cycle();
  endtask

  task automatic test_fairness;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, ADD, 128'(i), 128'(i), '0);
    for (int c = 0; c < 12; c++) begin
      exp_ready = 4'(1 << (c % 4));
      exp_rsp   = (c >= 3) ? 4'(1 << ((c - 3) % 4)) : 4'b0000;
      @(negedge clk);
      total++; if (req_ready !== exp_ready) begin
        bad++; $display("FAIL fair_ready c=%0d: got %b want %b", c, req_ready, exp_ready); end
      total++; if (rsp_valid !== exp_rsp) begin
        bad++; $display("FAIL fair_rsp c=%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      next_cycle();
    end
    clr();
    repeat (4) next_cycle();
  endtask

  task automatic test_bypass;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    do_reset();
    set_req(0, SUB, 128'd10, 128'd3, '0);
    for (int c = 0; c < 10; c++) begin
      req_valid[0] = (c <= 6);
      exp_ready = (c % 3 == 0 && c <= 6) ? 4'b0001 : 4'b0000;
      exp_rsp   = (c >= 3 && c % 3 == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      total++; if (req_ready !== exp_ready) begin
        bad++; $display("FAIL bypass_ready c=%0d: got %b want %b", c, req_ready, exp_ready); end
      total++; if (rsp_valid !== exp_rsp) begin
        bad++; $display("FAIL bypass_rsp c=%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      if (exp_rsp[0]) begin
        total++; if (rsp_data !== 128'd7) begin
          bad++; $display("FAIL bypass_data c=%0d: got %h want 7", c, rsp_data); end
      end
      next_cycle();
    end
    clr();
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    set_req(0, ADD, 128'd1, 128'd1, '0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ready0: got %b want 0001", req_ready); end
    next_cycle(); clr();
    set_req(1, ADD, 128'd2, 128'd2, '0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_ready1: got %b want 0010", req_ready); end
    next_cycle(); clr();
    rst_n = 1'b0;
    for (int c = 2; c < 9; c++) begin
      if (c == 4) rst_n = 1'b1;
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0000) begin
        bad++; $display("FAIL mid_rsp c=%0d: got %b want 0000", c, rsp_valid); end
      if (c >= 4) begin
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_idle c=%0d: got %b want 1", c, idle); end
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) set_req(i, ADD, 128'd0, 128'd0, '0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    next_cycle(); clr();
    repeat (4) next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_shift  = '0;
    test_reset();
    test_single();
    test_tag_routing();
    test_overflow();
    test_fairness();
    test_bypass();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
